// File: rtl/uart_pkg.sv
// Shared types and line levels for the asynchronous serial link.
// The transmitter and the receiver both use these framing definitions.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/tx_bit_timer.sv
// Rollover counter that marks the last clock of every serial bit period.
// It has a synchronous clear and an enable, and produces a one-cycle rollover flag.
module tx_bit_timer #(
    parameter int ROLLOVER_VAL = 10,
    parameter int CNT_W        = $clog2(ROLLOVER_VAL + 1)
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic rollover
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(ROLLOVER_VAL - 1);
    localparam logic [CNT_W-1:0] TOP_VAL  = CNT_W'(ROLLOVER_VAL);

    logic [CNT_W-1:0] count;

    assign rollover = enable && (count == LAST_VAL);

    // After a clear, the first period starts counting at 0. Each later period
    // starts at TOP_VAL and then wraps to 1. Either way, every period is
    // exactly ROLLOVER_VAL cycles long.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == TOP_VAL) begin
                count <= CNT_W'(1);
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Serial transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Every output is registered from the next-state values, so an accepted request
// is visible on the line in the cycle right after the accepting edge.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 10,
    parameter int NUM_DATA_BITS = 8,
    parameter int PARITY_EN     = 0
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     tx_start,
    input  logic [NUM_DATA_BITS-1:0] tx_data,
    output logic                     serial_out,
    output logic                     tx_busy,
    output logic                     tx_done
);

    localparam int IDX_W = $clog2(NUM_DATA_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DATA_BITS - 1);

    tx_state_t state;
    tx_state_t next_state;

    logic [NUM_DATA_BITS-1:0] shift_reg;
    logic [NUM_DATA_BITS-1:0] shift_next;
    logic [IDX_W-1:0]         bit_idx;
    logic [IDX_W-1:0]         idx_next;
    logic                     parity_bit;
    logic                     parity_next;
    logic                     serial_next;
    logic                     busy_next;
    logic                     done_next;
    logic                     accept;
    logic                     rollover;

    tx_bit_timer #(
        .ROLLOVER_VAL(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (accept),
        .enable  (state != IDLE),
        .rollover(rollover)
    );

    // The line level is derived from the state being entered rather than the
    // current state. Because of this, a request accepted in the tx_done cycle
    // starts its start bit with no idle gap.
    always_comb begin
        next_state  = state;
        shift_next  = shift_reg;
        idx_next    = bit_idx;
        parity_next = parity_bit;
        accept      = 1'b0;
        done_next   = 1'b0;

        case (state)
            IDLE: begin
                if (tx_start) begin
                    accept      = 1'b1;
                    next_state  = START;
                    shift_next  = tx_data;
                    parity_next = ^tx_data;
                end
            end
            START: begin
                if (rollover) begin
                    next_state = DATA;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (rollover) begin
                    shift_next = shift_reg >> 1;
                    if (bit_idx == LAST_IDX) begin
                        next_state = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_next = bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (rollover) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (rollover) begin
                    next_state = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        case (next_state)
            START:   serial_next = START_LEVEL;
            DATA:    serial_next = shift_next[0];
            PARITY:  serial_next = parity_next;
            STOP:    serial_next = STOP_LEVEL;
            default: serial_next = IDLE_LEVEL;
        endcase

        busy_next = (next_state != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_idx    <= '0;
            parity_bit <= 1'b0;
            serial_out <= IDLE_LEVEL;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= next_state;
            shift_reg  <= shift_next;
            bit_idx    <= idx_next;
            parity_bit <= parity_next;
            serial_out <= serial_next;
            tx_busy    <= busy_next;
            tx_done    <= done_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx. It drives one instance without parity (dut0) and one with
// even parity (dut1), and checks every line cycle against the expected frame.
module tb_uart_tx;

    localparam int CLKS = 10;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start0;
    logic       start1;
    logic       sel;
    logic [7:0] tx_data;
    logic       serial0, busy0, done0;
    logic       serial1, busy1, done1;
    logic       obs_serial, obs_busy, obs_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sel;
        logic [7:0]  data;
        logic [11:0] exp_bits;
        int          nbits;
        logic        noise;
        logic        chain;
    } vec_t;

    vec_t tbl[6];

    uart_tx #(.CLKS_PER_BIT(CLKS), .NUM_DATA_BITS(8), .PARITY_EN(0)) dut0 (
        .clk       (clk),
        .n_rst     (n_rst),
        .tx_start  (start0),
        .tx_data   (tx_data),
        .serial_out(serial0),
        .tx_busy   (busy0),
        .tx_done   (done0)
    );

    uart_tx #(.CLKS_PER_BIT(CLKS), .NUM_DATA_BITS(8), .PARITY_EN(1)) dut1 (
        .clk       (clk),
        .n_rst     (n_rst),
        .tx_start  (start1),
        .tx_data   (tx_data),
        .serial_out(serial1),
        .tx_busy   (busy1),
        .tx_done   (done1)
    );

    assign obs_serial = sel ? serial1 : serial0;
    assign obs_busy   = sel ? busy1   : busy0;
    assign obs_done   = sel ? done1   : done0;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic setStart(input logic v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    task automatic applyStimulus(input logic which, input logic [7:0] d);
        sel     = which;
        tx_data = d;
        setStart(1'b1);
    endtask

    // Expected line level for each bit period, in the order the bits go out.
    function automatic logic [11:0] modelBits(input logic [7:0] d, input logic par);
        logic [11:0] b;
        b    = '0;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = d[i];
        if (par) begin
            b[9]  = ^d;
            b[10] = 1'b1;
        end else begin
            b[9] = 1'b1;
        end
        return b;
    endfunction

    // Called at the negedge where tx_start was raised.
    // Returns at the negedge of the cycle that should carry tx_done.
    task automatic checkFrame(input string tag, input logic [11:0] exp_bits,
                              input int nbits, input logic noise);
        int good;
        for (int b = 0; b < nbits; b++) begin
            good = 0;
            for (int c = 0; c < CLKS; c++) begin
                @(negedge clk);
                if (obs_serial == exp_bits[b] && obs_busy && !obs_done) good++;
                if (b == 0 && c == 0) setStart(1'b0);
                if (noise && b >= 2 && b <= 5) begin
                    setStart((c % 2) == 0);
                    tx_data = 8'hFF;
                end
                if (noise && b == 6) setStart(1'b0);
            end
            checkOutput($sformatf("%s_bit%0d", tag, b), good, CLKS);
        end
        @(negedge clk);
        checkOutput({tag, "_done_cycle"}, int'({obs_done, obs_busy, obs_serial}), 3'b101);
    endtask

    task automatic checkIdle(input string tag, input int cycles);
        int good;
        good = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (obs_serial && !obs_busy && !obs_done) good++;
        end
        checkOutput(tag, good, cycles);
    endtask

    initial begin
        int         g0;
        int         g1;
        logic       w;
        logic [7:0] d;

        n_rst   = 1'b0;
        sel     = 1'b0;
        start0  = 1'b1;
        start1  = 1'b1;
        tx_data = 8'hA5;

        tbl[0] = '{1'b0, 8'hA5, 12'b001101001010, 10, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'hA5, 12'b010101001010, 11, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'h07, 12'b011000001110, 11, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'h3C, 12'b001001111000, 10, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'h12, 12'b001000100100, 10, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 8'h55, 12'b001010101010, 10, 1'b0, 1'b0};

        // Hold reset with tx_start high. Both lines must stay idle.
        g0 = 0;
        g1 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (serial0 && !busy0 && !done0) g0++;
            if (serial1 && !busy1 && !done1) g1++;
        end
        checkOutput("reset_idle_dut0", g0, 6);
        checkOutput("reset_idle_dut1", g1, 6);
        start0 = 1'b0;
        start1 = 1'b0;
        n_rst  = 1'b1;
        checkIdle("post_reset_idle", 2);

        // Table vectors. A chained vector is started in the tx_done cycle of the previous one.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(tbl[i].sel, tbl[i].data);
            checkFrame($sformatf("vec%0d", i), tbl[i].exp_bits, tbl[i].nbits, tbl[i].noise);
            if (!tbl[i].chain) checkIdle($sformatf("vec%0d_idle", i), 3);
        end

        // Reset pulse during data bit 3 of 0xC3. Bit 3 is 0, so the line is low at that point.
        applyStimulus(1'b0, 8'hC3);
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            if (i == 0) setStart(1'b0);
        end
        checkOutput("pre_reset_line", int'(serial0), 0);
        #1 n_rst = 1'b0;
        #1;
        checkOutput("async_reset_line", int'(serial0), 1);
        checkOutput("async_reset_busy", int'(busy0), 0);
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        checkIdle("abandoned_frame_quiet", 120);
        d = 8'($urandom);
        applyStimulus(1'b0, d);
        checkFrame("after_reset", modelBits(d, 1'b0), 10, 1'b0);
        checkIdle("after_reset_idle", 1);

        // Random bytes on randomly chosen instances, checked against the frame model.
        for (int r = 0; r < 8; r++) begin
            w = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            applyStimulus(w, d);
            checkFrame($sformatf("rand%0d", r), modelBits(d, w), w ? 11 : 10, 1'b0);
            checkIdle($sformatf("rand%0d_idle", r), $urandom_range(1, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the team's 8N1-style asynchronous link: it accepts a parallel byte through a start/busy handshake and shifts it out on a single line with a start bit, LSB-first data, an optional even parity bit and a stop bit. Bit timing comes from a parameterised rollover counter clocked by the system clock. It is the transmit end of the link whose receive end is the existing receiver block, and uses the same framing and bit period.

## Interface
- CLKS_PER_BIT, 10, system clocks per serial bit; legal range ≥ 2.
- NUM_DATA_BITS, 8, data bits per frame; legal range 5–9.
- PARITY_EN, 0, 1 inserts an even parity bit after the data bits.

- clk  input  1  system clock, rising edge.
- n_rst  input  1  reset, asynchronous, active-low.
- tx_start  input  1  request to send tx_data; sampled only when tx_busy = 0.
- tx_data  input  NUM_DATA_BITS  byte to send; captured on the accepting edge.
- serial_out  output  1  serial line; idle high.
- tx_busy  output  1  frame in progress; high from the cycle after acceptance through the last stop-bit cycle.
- tx_done  output  1  one-cycle pulse after the stop bit completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. The state type lives in the package.
- IDLE: serial_out = 1 and tx_busy = 0. If tx_start = 1, latch tx_data into the shift register and go to START. The parity register is set to the XOR of tx_data.
- START: serial_out = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: serial_out = shift_reg[0]. The register shifts right once per bit period, so bits go out LSB first. After NUM_DATA_BITS periods, go to PARITY if PARITY_EN = 1, otherwise go to STOP.
- PARITY: serial_out = the latched parity bit for one bit period, then go to STOP.
- STOP: serial_out = 1 for one bit period, then go to IDLE and assert tx_done for that first IDLE cycle.
- tx_start while tx_busy = 1 is ignored. It is not queued.
- Changes on tx_data after acceptance have no effect on the frame in flight.
- tx_start in the same cycle as tx_done is accepted. Back-to-back frames therefore have zero idle gap.
- Bit timer:
  - Counts 1..CLKS_PER_BIT. It is cleared on acceptance and enabled in every non-IDLE state.
  - Its rollover advances the bit index and state.
  - Bit index width is $clog2(NUM_DATA_BITS+1).

## Timing
- Reset values: serial_out = 1, tx_busy = 0, tx_done = 0, state IDLE, counters 0. Reset takes effect asynchronously.
- Reset mid-frame: the line goes high immediately and the frame is abandoned. No tx_done is issued.
- All outputs are registered. There is no combinational path from input to output.
- Latency: tx_start is sampled high at edge k. At edge k+1, serial_out falls and tx_busy rises.
- Each bit is held exactly CLKS_PER_BIT cycles.
- Frame length F = (2 + NUM_DATA_BITS + PARITY_EN) × CLKS_PER_BIT cycles.
- tx_done is high for cycle k+F+1 only. tx_busy falls in that same cycle.

## Structure
- Package uart_pkg holds:
  - tx_state_t enum.
  - Localparams IDLE_LEVEL = 1, START_LEVEL = 0, STOP_LEVEL = 1.
- Sub-module tx_bit_timer: parameterised rollover counter with clear, enable, rollover value and a one-cycle rollover flag. It is instantiated once with rollover value CLKS_PER_BIT.
- The FSM, shift register and parity register stay in uart_tx.

## Test plan
- Reset with tx_start held high and n_rst low: serial_out = 1, tx_busy = 0, tx_done = 0 throughout; no frame starts until n_rst rises.
- Send 0xA5 with defaults (CLKS_PER_BIT = 10, PARITY_EN = 0):
  - Line sequence is 0, 1, 0, 1, 0, 0, 1, 0, 1, 1, each bit held 10 cycles.
  - tx_busy stays high for 100 cycles, then tx_done pulses once.
- PARITY_EN = 1:
  - Send 0xA5; the parity bit is 0 (four ones) and the frame is 110 cycles.
  - Send 0x07; the parity bit is 1.
- Toggle tx_start and tx_data = 0xFF mid-frame while sending 0x3C: the line still carries 0x3C and no second frame starts.
- Assert tx_start = 1 with 0x55 in the tx_done cycle after a 0x12 frame: the start bit of 0x55 begins the next cycle, and tx_busy low is only that single cycle.
- Pulse n_rst low during data bit 3: the line goes to 1 asynchronously, no tx_done occurs, and the next tx_start sends a complete, correct frame.
